// File: rtl/cs_next_address_sequencer.sv
// Next-address microsequencer: with the address incrementer it forms the
// microprogram counter. Drives CSAddress/ACK combinationally so the chosen
// address becomes the incrementer's registered uPC on the very next edge.
// Call/return use a small internal LIFO of return addresses.
module cs_next_address_sequencer #(
    parameter int unsigned CSAI_DATAWIDTH = 11,
    parameter int unsigned STACK_DEPTH    = 4
) (
    input  logic                      ADDRESS_INCREMENTER_CLOCK_50,
    input  logic                      ADDRESS_INCREMENTER_RESET_InHigh,
    input  logic [CSAI_DATAWIDTH-1:0] SEQ_CSAI_InBus,
    input  logic                      SEQ_Start_In,
    input  logic [2:0]                SEQ_Op_InBus,
    input  logic [CSAI_DATAWIDTH-1:0] SEQ_BranchAddr_InBus,
    input  logic [CSAI_DATAWIDTH-1:0] SEQ_DispatchAddr_InBus,
    input  logic                      SEQ_Cond_In,
    input  logic                      SEQ_Ready_In,
    output logic [CSAI_DATAWIDTH-1:0] SEQ_CSAddress_OutBus,
    output logic                      SEQ_ACK_Out,
    output logic                      SEQ_Halted_Out,
    output logic                      SEQ_Overflow_Out,
    output logic                      SEQ_Underflow_Out
);

    localparam int unsigned W     = CSAI_DATAWIDTH;
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_CONT = 3'b000,
        OP_JUMP = 3'b001,
        OP_CJMP = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100,
        OP_DISP = 3'b101,
        OP_WAIT = 3'b110,
        OP_HALT = 3'b111
    } op_t;

    state_t          state;
    state_t          state_next;
    logic [SP_W-1:0] sp;
    logic [W-1:0]    stack [STACK_DEPTH];
    logic            overflow_q;
    logic            underflow_q;

    logic            push;
    logic            pop;
    logic            set_overflow;
    logic            set_underflow;

    logic [W-1:0]    return_addr;
    logic [W-1:0]    top_of_stack;
    logic            stack_full;
    logic            stack_empty;

    // Stack status and the return address a CALL would push
    assign return_addr  = SEQ_CSAI_InBus + W'(1);
    assign stack_full   = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty  = (sp == '0);
    assign top_of_stack = stack[IDX_W'(sp - SP_W'(1))];

    // State register, return stack and sticky error flags
    always_ff @(posedge ADDRESS_INCREMENTER_CLOCK_50 or posedge ADDRESS_INCREMENTER_RESET_InHigh) begin
        if (ADDRESS_INCREMENTER_RESET_InHigh) begin
            state       <= ST_IDLE;
            sp          <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (push) begin
                stack[IDX_W'(sp)] <= return_addr;
                sp                <= sp + SP_W'(1);
            end else if (pop) begin
                sp <= sp - SP_W'(1);
            end
            if (set_overflow) begin
                overflow_q <= 1'b1;
            end
            if (set_underflow) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Next state, next address and stack control from state and current op
    always_comb begin
        state_next           = state;
        SEQ_CSAddress_OutBus = SEQ_CSAI_InBus;
        SEQ_ACK_Out          = 1'b0;
        push                 = 1'b0;
        pop                  = 1'b0;
        set_overflow         = 1'b0;
        set_underflow        = 1'b0;

        unique case (state)
            ST_IDLE, ST_HALT: begin
                if (SEQ_Start_In) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                case (op_t'(SEQ_Op_InBus))
                    OP_CONT: begin
                        SEQ_ACK_Out = 1'b1;
                    end
                    OP_JUMP: begin
                        SEQ_CSAddress_OutBus = SEQ_BranchAddr_InBus;
                    end
                    OP_CJMP: begin
                        if (SEQ_Cond_In) begin
                            SEQ_CSAddress_OutBus = SEQ_BranchAddr_InBus;
                        end else begin
                            SEQ_ACK_Out = 1'b1;
                        end
                    end
                    OP_CALL: begin
                        if (stack_full) begin
                            set_overflow = 1'b1;
                            state_next   = ST_HALT;
                        end else begin
                            SEQ_CSAddress_OutBus = SEQ_BranchAddr_InBus;
                            push                 = 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (stack_empty) begin
                            set_underflow = 1'b1;
                            state_next    = ST_HALT;
                        end else begin
                            SEQ_CSAddress_OutBus = top_of_stack;
                            pop                  = 1'b1;
                        end
                    end
                    OP_DISP: begin
                        SEQ_CSAddress_OutBus = SEQ_DispatchAddr_InBus;
                    end
                    OP_WAIT: begin
                        SEQ_ACK_Out = SEQ_Ready_In;
                    end
                    OP_HALT: begin
                        state_next = ST_HALT;
                    end
                    default: begin
                        state_next = ST_HALT;
                    end
                endcase
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Status outputs
    assign SEQ_Halted_Out    = (state == ST_HALT);
    assign SEQ_Overflow_Out  = overflow_q;
    assign SEQ_Underflow_Out = underflow_q;

endmodule
